// File: rtl/enable_sequencer_a.sv
// Burst enable sequencer: issues burst_len step strobes (stall-gated), then drains the valid pipe and pulses done.
// Optional macro ENSEQ_ABORT_EN adds an abort input that cancels a burst in RUN or DRAIN.
`default_nettype none

module enable_sequencer_a #(
  parameter int LEN_W    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             stall,
`ifdef ENSEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             enable,
  output logic             valid_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] step_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [3:0]       DRAIN_LAST = 4'(PIPE_LAT - 1);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [LEN_W-1:0]      step_q, step_d;
  logic [3:0]            drain_q, drain_d;
  logic [PIPE_LAT-1:0]   shift_q, shift_d;
  logic                  abort_hit;

`ifdef ENSEQ_ABORT_EN
  assign abort_hit = abort && ((state_q == RUN) || (state_q == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // A burst_len of zero wraps on the first decrement, giving 2^LEN_W steps.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    step_d  = step_q;
    drain_d = drain_q;
    enable  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = burst_len;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        enable = !stall;
        if (!stall) begin
          rem_d  = rem_q - LEN_ONE;
          step_d = step_q + LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = DRAIN;
            drain_d = DRAIN_LAST;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) state_d = DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_comb begin
    shift_d    = '0;
    shift_d[0] = enable;
    for (int i = 1; i < PIPE_LAT; i++) shift_d[i] = shift_q[i-1];
    if (abort_hit) shift_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      step_q  <= '0;
      drain_q <= 4'd0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      shift_q <= shift_d;
    end
  end

  assign valid_out = shift_q[PIPE_LAT-1];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign step_cnt  = step_q;

endmodule

`default_nettype wire
